mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Responder end of the caches_if protocol: services icache instruction fetches and dcache word reads and writes against a single-ported RAM.
- Sits between the two L1 caches and the RAM model.
- Arbitrates one word transaction at a time and drives the iwait/dwait handshakes that the cache FSMs step on.
- Adds a turnaround cycle, icache anti-starvation and a RAM timeout monitor.

Parameters:
- ISTARVE, 4: max consecutive dcache grants while iREN pending before icache is forced a grant.
- TIMEOUT, 64: cycles a granted access may remain non-ACCESS before err is raised.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the completing cycle of a dcache access
- dload  out  32  dcache read data
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the completing cycle of an icache access
- iload  out  32  icache read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3
- err  out  1  sticky fault flag (RAM ERROR or timeout)

Behaviour:
- Reset (RST high at posedge):
  - state=IDLE; starve counter=0; timeout counter=0; err=0.
  - Outputs during and after reset until a grant: dwait=1, iwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dload=0, iload=0.
- Waits default high: a wait is low only in the single cycle its access completes.
- FSM, registered state:
  - IDLE:
    - Grant decision uses registered starve count and current requests.
    - (dREN|dWEN) and not(iREN and starve==ISTARVE) -> DGNT.
    - else iREN -> IGNT.
    - else stay.
  - DGNT:
    - ramaddr=daddr.
    - dWEN has precedence when both dWEN and dREN asserted: ramWEN=1, ramstore=dstore, ramREN=0.
    - Otherwise ramREN=1.
    - On ramstate==ACCESS: dwait=0, dload=ramload (read only; 0 on write), then -> TURN.
    - If dREN and dWEN both drop before ACCESS (aborted request): enables drop same cycle, -> IDLE, no handshake.
  - IGNT:
    - ramaddr=iaddr, ramREN=1.
    - On ACCESS: iwait=0, iload=ramload, -> TURN.
    - iREN drop aborts -> IDLE.
  - TURN:
    - One cycle; all RAM enables low and both waits high.
    - Lets requesters advance address (e.g. dcache WB1->WB2, READ1->READ2).
    - -> IDLE.
- Addresses and data are passed combinationally from the granted requester while in the grant state; there is no capture.
- Per-access latency: 1 cycle (IDLE) + RAM latency + 1 TURN. Minimum 3 cycles from request to next accepted request.
- Starve counter:
  - On completing a dcache access while iREN is high: increment, saturating at ISTARVE.
  - On completing an icache access: clear.
  - If iREN is low at any IDLE cycle: clear.
- Timeout counter:
  - Clears on entry to DGNT/IGNT; increments each cycle in DGNT/IGNT without ACCESS.
  - Reaching TIMEOUT: err=1; FSM stays in grant and keeps retrying.
- ramstate==ERROR in a grant state:
  - err=1 (sticky until RST); wait stays high; request is held asserted (retry).
- ramstate ACCESS outside DGNT/IGNT: ignored.
- RST mid-access: FSM returns to IDLE next edge, enables drop; the in-flight access is abandoned without a handshake.

Test Plan:
- Icache only:
  - Stimulus: iREN=1, iaddr=0x40, RAM latency 2, ramload=0xDEADBEEF.
  - Required: iwait low exactly one cycle with iload=0xDEADBEEF; ramREN low in the following TURN cycle.
- Simultaneous requests:
  - Stimulus: dREN=1 daddr=0x100 and iREN=1 iaddr=0x0 in the same cycle.
  - Required: dcache completes first; icache completes next.
  - Required: no overlap of dwait=0 and iwait=0 in any cycle.
- Dirty writeback burst:
  - Stimulus: dWEN with 0x3100/0x1234, then 0x3104/0x5678.
  - Required: ramWEN with matching ramaddr/ramstore for each; two dwait pulses separated by TURN; ramREN never asserted.
- Starvation, ISTARVE=4:
  - Stimulus: continuous dREN plus iREN held high.
  - Required: exactly 4 dcache completions, then 1 icache completion, then dcache resumes.
- Fault:
  - Stimulus: ramstate held BUSY for 64 cycles in DGNT.
  - Required: err=1 at cycle 64; dwait still high.
  - Stimulus: then pulse ramstate=ERROR.
  - Required: err stays 1.
  - Stimulus: assert RST.
  - Required: err=0, state IDLE, all enables 0.
- Reset mid-access:
  - Stimulus: RST asserted in IGNT one cycle before ACCESS.
  - Required: no iwait=0 pulse; ramREN=0 the cycle after the reset edge.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: responder end of the caches_if protocol. Arbitrates single
// word transactions from the icache and dcache onto one single-ported RAM,
// drives the iwait/dwait handshakes, inserts a turnaround cycle after every
// completed access, protects the icache from starvation and watches the RAM
// for errors and stalls.
module mem_arbiter #(
  parameter int ISTARVE = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DGNT = 2'd1;
  localparam logic [1:0] IGNT = 2'd2;
  localparam logic [1:0] TURN = 2'd3;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam int SW = $clog2(ISTARVE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [SW-1:0] starve;
  logic [TW-1:0] tcount;
  logic          err_q;

  logic d_req;
  logic in_grant;
  logic ram_ok;
  logic starve_full;
  logic d_active;
  logic i_active;
  logic d_done;
  logic i_done;

  // Request qualifiers. Reset masks the grant so nothing reaches the RAM or
  // the caches while RST is high, even if the state register still shows a
  // grant from before the reset edge.
  always_comb begin
    d_req       = dREN | dWEN;
    in_grant    = (state == DGNT) || (state == IGNT);
    ram_ok      = (ramstate == RAM_ACCESS);
    starve_full = (starve == SW'(ISTARVE));
    d_active    = !RST && (state == DGNT) && d_req;
    i_active    = !RST && (state == IGNT) && iREN;
    d_done      = d_active && ram_ok;
    i_done      = i_active && ram_ok;
  end

  // Next-state decision: the dcache wins in IDLE unless the icache has been
  // passed over ISTARVE times; a dropped request aborts its grant.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_req && !(iREN && starve_full)) begin
          state_next = DGNT;
        end else if (iREN) begin
          state_next = IGNT;
        end
      end
      DGNT: begin
        if (!d_req) begin
          state_next = IDLE;
        end else if (ram_ok) begin
          state_next = TURN;
        end
      end
      IGNT: begin
        if (!iREN) begin
          state_next = IDLE;
        end else if (ram_ok) begin
          state_next = TURN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM and cache-side outputs, passed straight through from the granted
  // requester; writes take precedence when the dcache raises both enables.
  always_comb begin
    dwait    = 1'b1;
    iwait    = 1'b1;
    dload    = 32'h0;
    iload    = 32'h0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    if (d_active) begin
      ramaddr = daddr;
      if (dWEN) begin
        ramWEN   = 1'b1;
        ramstore = dstore;
      end else begin
        ramREN = 1'b1;
      end
      if (ram_ok) begin
        dwait = 1'b0;
        dload = dWEN ? 32'h0 : ramload;
      end
    end else if (i_active) begin
      ramaddr = iaddr;
      ramREN  = 1'b1;
      if (ram_ok) begin
        iwait = 1'b0;
        iload = ramload;
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Starve counter: counts dcache completions that the icache sat through,
  // and is cleared once the icache is served or stops asking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      starve <= '0;
    end else if (i_done) begin
      starve <= '0;
    end else if (d_done && iREN) begin
      if (!starve_full) begin
        starve <= starve + SW'(1);
      end
    end else if ((state == IDLE) && !iREN) begin
      starve <= '0;
    end
  end

  // Timeout counter and sticky error flag: a grant that never sees ACCESS
  // for TIMEOUT cycles, or any RAM ERROR during a grant, raises err; the
  // grant itself is held so the RAM keeps being retried.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tcount <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == IDLE) && (state_next != IDLE)) begin
        tcount <= '0;
      end else if (in_grant && !ram_ok) begin
        if (tcount != TW'(TIMEOUT)) begin
          tcount <= tcount + TW'(1);
        end
        if (tcount == TW'(TIMEOUT - 1)) begin
          err_q <= 1'b1;
        end
      end
      if (in_grant && (ramstate == RAM_ERROR)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter. Each vector
// gives one cycle of inputs and the outputs expected in that cycle; the
// starvation, timeout and RAM error cases are driven as short sequences.
module tb_mem_arbiter;

  localparam logic [1:0] FR = 2'd0;
  localparam logic [1:0] BS = 2'd1;
  localparam logic [1:0] AC = 2'd2;
  localparam logic [1:0] ER = 2'd3;

  logic        CLK;
  logic        RST;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         rst;
    logic         dren;
    logic         dwen;
    logic [31:0]  daddr;
    logic [31:0]  dstore;
    logic         iren;
    logic [31:0]  iaddr;
    logic [31:0]  rload;
    logic [1:0]   rstate;
    logic [132:0] exp;
  } vec_t;

  vec_t vecs[$];

  mem_arbiter #(.ISTARVE(4), .TIMEOUT(64)) dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  // 10 ns clock; inputs change on the falling edge.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [132:0] pack(input logic dw, input logic iw,
                                        input logic ren, input logic wen,
                                        input logic [31:0] addr, input logic [31:0] store,
                                        input logic [31:0] dld, input logic [31:0] ild,
                                        input logic e);
    return {dw, iw, ren, wen, addr, store, dld, ild, e};
  endfunction

  function automatic logic [132:0] outs();
    return {dwait, iwait, ramREN, ramWEN, ramaddr, ramstore, dload, iload, err};
  endfunction

  task automatic check_output(input string name, input logic [132:0] got,
                              input logic [132:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic rst, input logic dren, input logic dwen,
                                input logic [31:0] da, input logic [31:0] ds,
                                input logic iren, input logic [31:0] ia,
                                input logic [31:0] rl, input logic [1:0] rs);
    RST      = rst;
    dREN     = dren;
    dWEN     = dwen;
    daddr    = da;
    dstore   = ds;
    iREN     = iren;
    iaddr    = ia;
    ramload  = rl;
    ramstate = rs;
  endtask

  // Advance to the next falling edge, drive, then let outputs settle.
  task automatic step(input logic rst, input logic dren, input logic dwen,
                      input logic [31:0] da, input logic [31:0] ds,
                      input logic iren, input logic [31:0] ia,
                      input logic [31:0] rl, input logic [1:0] rs);
    @(negedge CLK);
    apply_stimulus(rst, dren, dwen, da, ds, iren, ia, rl, rs);
    #2;
  endtask

  task automatic add_vec(input logic rst, input logic dren, input logic dwen,
                         input logic [31:0] da, input logic [31:0] ds,
                         input logic iren, input logic [31:0] ia,
                         input logic [31:0] rl, input logic [1:0] rs,
                         input logic [132:0] exp);
    vec_t v;
    v.rst = rst; v.dren = dren; v.dwen = dwen; v.daddr = da; v.dstore = ds;
    v.iren = iren; v.iaddr = ia; v.rload = rl; v.rstate = rs; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic reset_dut();
    step(1, 0, 0, 0, 0, 0, 0, 0, FR);
    step(0, 0, 0, 0, 0, 0, 0, 0, FR);
  endtask

  initial begin
    logic [132:0] idle;
    byte          seq[$];
    byte          want[6];
    int           cyc;

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0, FR);
    idle = pack(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Reset, then icache fetch with RAM latency 2.
    add_vec(1, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 1, 32'h40, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 1, 32'h40, 0, BS, pack(1, 1, 1, 0, 32'h40, 0, 0, 0, 0));
    add_vec(0, 0, 0, 0, 0, 1, 32'h40, 32'hDEADBEEF, AC,
            pack(1, 0, 1, 0, 32'h40, 0, 0, 32'hDEADBEEF, 0));
    add_vec(0, 0, 0, 0, 0, 0, 32'h40, 32'hDEADBEEF, FR, idle);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    // Simultaneous requests: dcache first, then icache.
    add_vec(0, 1, 0, 32'h100, 0, 1, 0, 0, FR, idle);
    add_vec(0, 1, 0, 32'h100, 0, 1, 0, 0, BS, pack(1, 1, 1, 0, 32'h100, 0, 0, 0, 0));
    add_vec(0, 1, 0, 32'h100, 0, 1, 0, 32'hCAFE0001, AC,
            pack(0, 1, 1, 0, 32'h100, 0, 32'hCAFE0001, 0, 0));
    add_vec(0, 0, 0, 32'h100, 0, 1, 0, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 1, 0, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 1, 0, 32'h11112222, AC,
            pack(1, 0, 1, 0, 0, 0, 0, 32'h11112222, 0));
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    // Dirty writeback burst of two words.
    add_vec(0, 0, 1, 32'h3100, 32'h1234, 0, 0, 0, FR, idle);
    add_vec(0, 0, 1, 32'h3100, 32'h1234, 0, 0, 0, BS,
            pack(1, 1, 0, 1, 32'h3100, 32'h1234, 0, 0, 0));
    add_vec(0, 0, 1, 32'h3100, 32'h1234, 0, 0, 32'hFFFFFFFF, AC,
            pack(0, 1, 0, 1, 32'h3100, 32'h1234, 0, 0, 0));
    add_vec(0, 0, 1, 32'h3104, 32'h5678, 0, 0, 0, FR, idle);
    add_vec(0, 0, 1, 32'h3104, 32'h5678, 0, 0, 0, FR, idle);
    add_vec(0, 0, 1, 32'h3104, 32'h5678, 0, 0, 0, AC,
            pack(0, 1, 0, 1, 32'h3104, 32'h5678, 0, 0, 0));
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    // dWEN wins over dREN.
    add_vec(0, 1, 1, 32'h200, 32'hAA, 0, 0, 0, FR, idle);
    add_vec(0, 1, 1, 32'h200, 32'hAA, 0, 0, 32'h5, AC,
            pack(0, 1, 0, 1, 32'h200, 32'hAA, 0, 0, 0));
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);
    // Aborted dcache read, then ACCESS in IDLE is ignored.
    add_vec(0, 1, 0, 32'h300, 0, 0, 0, 0, FR, idle);
    add_vec(0, 1, 0, 32'h300, 0, 0, 0, 0, BS, pack(1, 1, 1, 0, 32'h300, 0, 0, 0, 0));
    add_vec(0, 0, 0, 32'h300, 0, 0, 0, 32'h77, AC, idle);
    add_vec(0, 0, 0, 32'h300, 0, 0, 0, 32'h77, AC, idle);
    // Reset one cycle before ACCESS in IGNT.
    add_vec(0, 0, 0, 0, 0, 1, 32'h80, 0, FR, idle);
    add_vec(0, 0, 0, 0, 0, 1, 32'h80, 0, BS, pack(1, 1, 1, 0, 32'h80, 0, 0, 0, 0));
    add_vec(1, 0, 0, 0, 0, 1, 32'h80, 32'h99, BS, idle);
    add_vec(0, 0, 0, 0, 0, 1, 32'h80, 32'h99, AC, idle);
    add_vec(0, 0, 0, 0, 0, 0, 32'h80, 32'h99, FR, idle);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, FR, idle);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].dren, vecs[i].dwen, vecs[i].daddr, vecs[i].dstore,
           vecs[i].iren, vecs[i].iaddr, vecs[i].rload, vecs[i].rstate);
      check_output($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Starvation: continuous dREN and iREN, RAM always ready.
    reset_dut();
    want[0] = "D"; want[1] = "D"; want[2] = "D";
    want[3] = "D"; want[4] = "I"; want[5] = "D";
    cyc = 0;
    while (seq.size() < 6 && cyc < 100) begin
      step(0, 1, 0, 32'h400, 0, 1, 32'h44, 32'h1, AC);
      check_output("no_overlap", {132'b0, dwait | iwait}, 133'd1);
      if (!dwait) seq.push_back("D");
      if (!iwait) seq.push_back("I");
      cyc++;
    end
    check_output("starve_budget", {132'b0, seq.size() >= 6}, 133'd1);
    for (int k = 0; k < 6; k++) begin
      if (k < seq.size()) begin
        check_output($sformatf("starve_order%0d", k), {125'b0, seq[k]}, {125'b0, want[k]});
      end
    end

    // Timeout: ramstate held BUSY in DGNT.
    reset_dut();
    step(0, 1, 0, 32'h500, 0, 0, 0, 0, BS);
    for (int k = 1; k <= 64; k++) begin
      step(0, 1, 0, 32'h500, 0, 0, 0, 0, BS);
      if (k == 1) check_output("tmo_grant", outs(), pack(1, 1, 1, 0, 32'h500, 0, 0, 0, 0));
    end
    check_output("tmo_err_before", {132'b0, err}, 133'd0);
    step(0, 1, 0, 32'h500, 0, 0, 0, 0, BS);
    check_output("tmo_err_set", outs(), pack(1, 1, 1, 0, 32'h500, 0, 0, 0, 1));
    step(0, 1, 0, 32'h500, 0, 0, 0, 0, ER);
    check_output("tmo_err_pulse", outs(), pack(1, 1, 1, 0, 32'h500, 0, 0, 0, 1));
    step(0, 1, 0, 32'h500, 0, 0, 0, 0, BS);
    check_output("tmo_err_sticky", {132'b0, err}, 133'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0, FR);
    step(0, 0, 0, 0, 0, 0, 0, 0, FR);
    check_output("tmo_after_rst", outs(), idle);

    // RAM ERROR then ACCESS: err set, access still completes on retry.
    step(0, 1, 0, 32'h600, 0, 0, 0, 0, BS);
    step(0, 1, 0, 32'h600, 0, 0, 0, 0, ER);
    check_output("ramerr_hold", outs(), pack(1, 1, 1, 0, 32'h600, 0, 0, 0, 0));
    step(0, 1, 0, 32'h600, 0, 0, 0, 32'h42, AC);
    check_output("ramerr_retry", outs(), pack(0, 1, 1, 0, 32'h600, 0, 32'h42, 0, 1));
    step(0, 0, 0, 0, 0, 0, 0, 0, FR);
    check_output("ramerr_turn", outs(), pack(1, 1, 0, 0, 0, 0, 0, 0, 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
